// File: rtl/phase_seq_pkg.sv
// Shared types and helpers for the multi-phase enable generator.
`timescale 1ns/1ps
package phase_seq_pkg;

  // Sequencer states: idle (no phase active), running, paused (phase frozen).
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Upper bound on the phase count supported by the one-hot helper.
  localparam int MAX_PHASES = 64;

  // One-hot vector with bit idx set; callers size-cast to their phase count.
  function automatic logic [MAX_PHASES-1:0] onehot_from_idx(input int unsigned idx);
    logic [MAX_PHASES-1:0] v;
    v = {{(MAX_PHASES-1){1'b0}}, 1'b1} << idx;
    return v;
  endfunction

endpackage

// File: rtl/phase_seq_gen_next_sel.sv
// Circular priority search: finds the next participating phase after cur_idx.
`timescale 1ns/1ps
module phase_next_sel
  import phase_seq_pkg::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int IDX_W      = $clog2(NUM_PHASES)
) (
  input  logic [NUM_PHASES-1:0] mask,
  input  logic [IDX_W-1:0]      cur_idx,
  output logic [IDX_W-1:0]      next_idx,
  output logic                  wrap,
  output logic                  none
);

  // Candidate index and wrap flag for each search offset 1..NUM_PHASES.
  // Offset NUM_PHASES lands back on cur_idx, which covers the single-bit mask.
  logic [IDX_W-1:0]      cand      [NUM_PHASES];
  logic [NUM_PHASES-1:0] cand_wrap;
  logic [NUM_PHASES-1:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PHASES; gi++) begin : g_cand
      localparam int OFF = gi + 1;
      logic [IDX_W:0] sum;
      // cur_idx + OFF stays below 2*NUM_PHASES, so one conditional subtract
      // is enough to reduce it modulo NUM_PHASES.
      assign sum          = {1'b0, cur_idx} + (IDX_W+1)'(OFF);
      assign cand_wrap[gi] = (sum >= (IDX_W+1)'(NUM_PHASES));
      assign cand[gi]     = cand_wrap[gi] ? IDX_W'(sum - (IDX_W+1)'(NUM_PHASES))
                                          : sum[IDX_W-1:0];
      assign hit[gi]      = mask[cand[gi]];
    end
  endgenerate

  // Smallest offset with a participating phase wins.
  always_comb begin
    next_idx = cur_idx;
    wrap     = 1'b0;
    for (int i = NUM_PHASES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        next_idx = cand[i];
        wrap     = cand_wrap[i];
      end
    end
    none = ~|mask;
  end

endmodule

// File: rtl/phase_seq_gen.sv
// Multi-phase one-hot enable generator with per-phase dwell, phase masking,
// pause and synchronous restart. All outputs come straight from registers.
`timescale 1ns/1ps
module phase_seq_gen
  import phase_seq_pkg::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int CNT_W      = 8,
  parameter int IDX_W      = $clog2(NUM_PHASES)
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  en_in,
  input  logic                  sync_clr_in,
  input  logic [CNT_W-1:0]      dwell_in,
  input  logic [NUM_PHASES-1:0] phase_mask_in,
  output logic [NUM_PHASES-1:0] phase_out,
  output logic [IDX_W-1:0]      phase_idx_out,
  output logic                  round_done_out,
  output logic                  active_out
);

  state_t                state_reg;
  logic [IDX_W-1:0]      idx_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [CNT_W-1:0]      dwell_reg;
  logic [NUM_PHASES-1:0] phase_reg;
  logic                  round_done_reg;
  logic                  active_reg;

  logic [IDX_W-1:0]      first_idx;
  logic                  start_ok;
  logic [IDX_W-1:0]      adv_idx;
  logic                  adv_wrap;
  logic                  adv_none;
  logic [NUM_PHASES-1:0] first_oh;
  logic [NUM_PHASES-1:0] adv_oh;
  logic [NUM_PHASES-1:0] cur_oh;
  logic                  dwell_done;

  // Lowest participating phase, used on every (re)start of the sequence.
  always_comb begin
    first_idx = '0;
    for (int i = NUM_PHASES - 1; i >= 0; i--) begin
      if (phase_mask_in[i]) first_idx = IDX_W'(i);
    end
    start_ok = |phase_mask_in;
  end

  phase_next_sel #(
    .NUM_PHASES (NUM_PHASES),
    .IDX_W      (IDX_W)
  ) u_next_sel (
    .mask     (phase_mask_in),
    .cur_idx  (idx_reg),
    .next_idx (adv_idx),
    .wrap     (adv_wrap),
    .none     (adv_none)
  );

  // One-hot images of the candidate indices and the end-of-dwell condition.
  always_comb begin
    first_oh   = NUM_PHASES'(onehot_from_idx(int'(first_idx)));
    adv_oh     = NUM_PHASES'(onehot_from_idx(int'(adv_idx)));
    cur_oh     = NUM_PHASES'(onehot_from_idx(int'(idx_reg)));
    dwell_done = (cnt_reg == dwell_reg);
  end

  // Sequencer: restart has priority, then run/pause/mask handling per state.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= '0;
      cnt_reg        <= '0;
      dwell_reg      <= '0;
      phase_reg      <= '0;
      round_done_reg <= 1'b0;
      active_reg     <= 1'b0;
    end else if (sync_clr_in) begin
      cnt_reg        <= '0;
      round_done_reg <= 1'b0;
      if (en_in && start_ok) begin
        state_reg  <= ST_RUN;
        idx_reg    <= first_idx;
        dwell_reg  <= dwell_in;
        phase_reg  <= first_oh;
        active_reg <= 1'b1;
      end else begin
        state_reg  <= ST_IDLE;
        idx_reg    <= '0;
        phase_reg  <= '0;
        active_reg <= 1'b0;
      end
    end else begin
      case (state_reg)
        ST_IDLE: begin
          round_done_reg <= 1'b0;
          // First entry never flags a completed round.
          if (en_in && start_ok) begin
            state_reg  <= ST_RUN;
            idx_reg    <= first_idx;
            cnt_reg    <= '0;
            dwell_reg  <= dwell_in;
            phase_reg  <= first_oh;
            active_reg <= 1'b1;
          end
        end

        ST_RUN: begin
          // The cycle just ending was a high cycle of the current phase, so it
          // is counted even when en_in drops at this edge.
          if (dwell_done) begin
            if (adv_none) begin
              state_reg      <= ST_IDLE;
              idx_reg        <= '0;
              cnt_reg        <= '0;
              phase_reg      <= '0;
              round_done_reg <= 1'b0;
              active_reg     <= 1'b0;
            end else begin
              idx_reg        <= adv_idx;
              cnt_reg        <= '0;
              dwell_reg      <= dwell_in;
              state_reg      <= en_in ? ST_RUN : ST_PAUSE;
              phase_reg      <= en_in ? adv_oh : '0;
              round_done_reg <= en_in & adv_wrap;
              active_reg     <= en_in;
            end
          end else begin
            cnt_reg        <= cnt_reg + 1'b1;
            round_done_reg <= 1'b0;
            if (!en_in) begin
              state_reg  <= ST_PAUSE;
              phase_reg  <= '0;
              active_reg <= 1'b0;
            end
          end
        end

        ST_PAUSE: begin
          // Index and count stay frozen; resume picks up the same phase.
          round_done_reg <= 1'b0;
          if (en_in) begin
            state_reg  <= ST_RUN;
            phase_reg  <= cur_oh;
            active_reg <= 1'b1;
          end
        end

        default: begin
          state_reg      <= ST_IDLE;
          idx_reg        <= '0;
          cnt_reg        <= '0;
          phase_reg      <= '0;
          round_done_reg <= 1'b0;
          active_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign phase_out      = phase_reg;
  assign phase_idx_out  = idx_reg;
  assign round_done_out = round_done_reg;
  assign active_out     = active_reg;

endmodule

// File: tb/tb_phase_seq_gen.sv
// Directed bench for phase_seq_gen with a queue-based scoreboard.
`timescale 1ns/1ps
module tb_phase_seq_gen;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic [7:0] dwell;
  logic [3:0] mask;
  logic [3:0] phase_out;
  logic [1:0] phase_idx_out;
  logic       round_done_out;
  logic       active_out;

  typedef struct packed {
    logic [3:0] phase;
    logic [1:0] idx;
    logic       rd;
    logic       act;
  } obs_t;

  obs_t  exp_q  [$];
  string name_q [$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    n_step   = 0;
  obs_t  mon_exp;
  obs_t  mon_got;
  string mon_name;

  phase_seq_gen #(
    .NUM_PHASES (4),
    .CNT_W      (8),
    .IDX_W      (2)
  ) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .en_in          (en),
    .sync_clr_in    (clr),
    .dwell_in       (dwell),
    .phase_mask_in  (mask),
    .phase_out      (phase_out),
    .phase_idx_out  (phase_idx_out),
    .round_done_out (round_done_out),
    .active_out     (active_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: each cycle the DUT presents a new registered output; compare it
  // against the oldest pending expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      mon_got  = '{phase: phase_out, idx: phase_idx_out, rd: round_done_out, act: active_out};
      n_checks++;
      if (mon_got !== mon_exp) begin
        n_fail++;
        $display("FAIL %s: got phase=%b idx=%0d rd=%b act=%b, expected phase=%b idx=%0d rd=%b act=%b",
                 mon_name, mon_got.phase, mon_got.idx, mon_got.rd, mon_got.act,
                 mon_exp.phase, mon_exp.idx, mon_exp.rd, mon_exp.act);
      end else begin
        $display("ok   %s: phase=%b idx=%0d rd=%b act=%b",
                 mon_name, mon_got.phase, mon_got.idx, mon_got.rd, mon_got.act);
      end
    end
  end

  // Apply inputs for one edge and queue the outputs expected after it.
  task automatic step(input logic e, input logic c, input logic [7:0] d, input logic [3:0] m,
                      input logic [3:0] ph, input logic [1:0] ix, input logic rd, input logic ac,
                      input string nm);
    obs_t x;
    en    = e;
    clr   = c;
    dwell = d;
    mask  = m;
    @(posedge clk);
    x = '{phase: ph, idx: ix, rd: rd, act: ac};
    n_step++;
    exp_q.push_back(x);
    name_q.push_back($sformatf("%s#%0d", nm, n_step));
    #1;
  endtask

  // Immediate comparison for checks that must not wait for a clock edge.
  task automatic check_now(input string nm, input obs_t ex);
    obs_t got;
    got = '{phase: phase_out, idx: phase_idx_out, rd: round_done_out, act: active_out};
    n_checks++;
    if (got !== ex) begin
      n_fail++;
      $display("FAIL %s: got phase=%b idx=%0d rd=%b act=%b, expected all zero",
               nm, got.phase, got.idx, got.rd, got.act);
    end else begin
      $display("ok   %s: outputs cleared", nm);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    clr   = 1'b0;
    dwell = 8'd0;
    mask  = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    check_now("reset_hold", '0);
    rst_n = 1'b1;

    // Reset state persists while en_in is low.
    step(0, 0, 0, 4'b1111, 4'b0000, 0, 0, 0, "idle_after_reset");

    // Legacy divider: dwell 0, full mask, rotate with a wrap pulse on phase 0.
    step(1, 0, 0, 4'b1111, 4'b0001, 0, 0, 1, "div_p0_first");
    step(1, 0, 0, 4'b1111, 4'b0010, 1, 0, 1, "div_p1");
    step(1, 0, 0, 4'b1111, 4'b0100, 2, 0, 1, "div_p2");
    step(1, 0, 0, 4'b1111, 4'b1000, 3, 0, 1, "div_p3");
    step(1, 0, 0, 4'b1111, 4'b0001, 0, 1, 1, "div_p0_wrap");
    step(1, 0, 0, 4'b1111, 4'b0010, 1, 0, 1, "div_p1");
    step(1, 0, 0, 4'b1111, 4'b0100, 2, 0, 1, "div_p2");
    step(1, 0, 0, 4'b1111, 4'b1000, 3, 0, 1, "div_p3");
    step(1, 0, 0, 4'b1111, 4'b0001, 0, 1, 1, "div_p0_wrap");

    // Dwell 2, mask 1010: phases 1 and 3 only, three cycles each.
    for (int i = 0; i < 3; i++) step(1, 0, 2, 4'b1010, 4'b0010, 1, 0, 1, "skip_p1");
    for (int i = 0; i < 3; i++) step(1, 0, 2, 4'b1010, 4'b1000, 3, 0, 1, "skip_p3");
    step(1, 0, 2, 4'b1010, 4'b0010, 1, 1, 1, "skip_p1_wrap");
    for (int i = 0; i < 2; i++) step(1, 0, 2, 4'b1010, 4'b0010, 1, 0, 1, "skip_p1");

    // Dwell 3: phase 3 for four cycles, then phase 1 paused after two cycles.
    for (int i = 0; i < 4; i++) step(1, 0, 3, 4'b1010, 4'b1000, 3, 0, 1, "dw3_p3");
    step(1, 0, 3, 4'b1010, 4'b0010, 1, 1, 1, "dw3_p1_wrap");
    step(1, 0, 3, 4'b1010, 4'b0010, 1, 0, 1, "dw3_p1");
    for (int i = 0; i < 5; i++) step(0, 0, 3, 4'b1111, 4'b0000, 1, 0, 0, "pause");
    step(1, 0, 3, 4'b1111, 4'b0010, 1, 0, 1, "resume_p1");
    step(1, 0, 3, 4'b1111, 4'b0010, 1, 0, 1, "resume_p1");
    step(1, 0, 3, 4'b1111, 4'b0100, 2, 0, 1, "resume_next_p2");

    // Single-bit mask: phase 2 finishes dwell 3, then repeats every 2 cycles.
    for (int i = 0; i < 3; i++) step(1, 0, 1, 4'b0100, 4'b0100, 2, 0, 1, "single_p2");
    step(1, 0, 1, 4'b0100, 4'b0100, 2, 1, 1, "single_wrap");
    step(1, 0, 1, 4'b0100, 4'b0100, 2, 0, 1, "single_p2");
    step(1, 0, 1, 4'b0100, 4'b0100, 2, 1, 1, "single_wrap");
    step(1, 0, 1, 4'b0100, 4'b0100, 2, 0, 1, "single_p2");
    // Empty mask at the advance point drops to idle and stays there.
    step(1, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, "mask0_idle");
    step(1, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, "mask0_stay");

    // Synchronous restart while in phase 3 (dwell 5 latched on entry).
    step(1, 0, 0, 4'b1111, 4'b0001, 0, 0, 1, "clr_setup_p0");
    step(1, 0, 0, 4'b1111, 4'b0010, 1, 0, 1, "clr_setup_p1");
    step(1, 0, 0, 4'b1111, 4'b0100, 2, 0, 1, "clr_setup_p2");
    step(1, 0, 5, 4'b1111, 4'b1000, 3, 0, 1, "clr_setup_p3");
    step(1, 0, 5, 4'b1111, 4'b1000, 3, 0, 1, "clr_setup_p3");
    step(1, 1, 5, 4'b1111, 4'b0001, 0, 0, 1, "clr_restart");
    step(1, 0, 5, 4'b1111, 4'b0001, 0, 0, 1, "clr_p0_hold");
    step(0, 1, 5, 4'b1111, 4'b0000, 0, 0, 0, "clr_en0_idle");

    // Asynchronous reset in the middle of a phase.
    step(1, 0, 0, 4'b1111, 4'b0001, 0, 0, 1, "arst_setup_p0");
    step(1, 0, 0, 4'b1111, 4'b0010, 1, 0, 1, "arst_setup_p1");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_now("arst_immediate", '0);
    @(posedge clk);
    #1;
    check_now("arst_held", '0);
    rst_n = 1'b1;
    step(1, 0, 0, 4'b1111, 4'b0001, 0, 0, 1, "arst_restart_p0");
    step(1, 0, 0, 4'b1111, 4'b0010, 1, 0, 1, "arst_p1");

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_seq_gen.md
Name: phase_seq_gen

Overview:
Parametrised multi-phase enable generator. It is the successor to the fixed 4-phase one-hot divider. Produces NUM_PHASES one-hot phase enables, each held for a programmable dwell, skips masked phases, and supports pause and synchronous restart. Sits after the board clock and drives per-program-slot enables in the multi-program placement datapath.

Parameters:
NUM_PHASES, 4, number of phase outputs (>=2)
CNT_W, 8, width of dwell counter/dwell input
IDX_W, $clog2(NUM_PHASES), width of phase index output (derived)

Ports:
clk_in  input  1  single system clock, all logic on posedge
rst_n_in  input  1  asynchronous, active-low reset
en_in  input  1  run enable; low pauses sequencing
sync_clr_in  input  1  synchronous restart of the sequence
dwell_in  input  CNT_W  cycles-per-phase minus 1; sampled at each phase entry
phase_mask_in  input  NUM_PHASES  1 = phase participates, 0 = skipped
phase_out  output  NUM_PHASES  one-hot active phase enable (all-0 when idle/paused)
phase_idx_out  output  IDX_W  index of current phase (held when paused)
round_done_out  output  1  1-cycle pulse on start of each new round after wrap
active_out  output  1  high in RUN state

Behaviour:
- Interface fixed: one clock (clk_in); reset asynchronous, active-low (rst_n_in). All outputs registered.
- Reset: state=IDLE, phase_out=0, phase_idx_out=0, round_done_out=0, active_out=0, dwell counter=0, latched dwell=0.
- States: IDLE, RUN, PAUSE.
- Priority per edge: rst_n_in > sync_clr_in > en_in/mask logic.
- IDLE: en_in=1 and phase_mask_in!=0 at edge k -> RUN after edge k; idx = lowest set mask bit, cnt=0, dwell latched from dwell_in, phase_out=onehot(idx). round_done_out not pulsed on first entry. Otherwise stay IDLE.
- RUN: cnt increments each cycle. When cnt==latched dwell, advance at that edge: idx = next set mask bit searched circularly from idx+1 using mask sampled at that edge; cnt=0; dwell re-latched. Each phase is therefore high exactly dwell+1 consecutive cycles.
- Wrap: if new idx <= old idx (circular wrap, including the single-bit mask case), round_done_out=1 for exactly the first cycle of the new phase.
- Mask==0 at an advance point -> IDLE, outputs cleared. Mask changes between advance points have no effect.
- RUN with en_in=0 -> PAUSE next edge: phase_out=0, active_out=0, idx and cnt frozen, round_done_out=0.
- PAUSE with en_in=1 -> RUN; same idx resumes and cnt continues from its frozen value. Total high cycles for the phase remain dwell+1.
- sync_clr_in=1 (any state): cnt=0, round_done_out=0. If en_in=1 and mask!=0 -> RUN at lowest set bit with fresh dwell latch, else IDLE.
- dwell_in=0, full mask: one cycle per phase, rotating 0,1,..,N-1,0 (legacy divider behaviour).
- phase_out is never multi-hot. Asserting rst_n_in mid-phase clears outputs immediately (async).

Decomposition:
- Package phase_seq_pkg: state enum (IDLE/RUN/PAUSE) and the onehot-from-index function.
- One sub-module: phase_next_sel, combinational circular priority search. Inputs: mask and current idx. Outputs: next idx, wrap flag, none flag.

Test Plan:
- Reset then en_in=1, N=4, dwell_in=0, mask=4'b1111 -> phase_out 0001,0010,0100,1000,0001...; round_done_out high with the second 0001 and every 4 cycles after.
- dwell_in=2, mask=4'b1010 -> phase_out 0010 x3 cycles, 1000 x3 cycles, 0010 (round_done_out=1 on its first cycle); phases 0 and 2 never asserted.
- dwell_in=3, drop en_in for 5 cycles after 2 cycles in phase 1 -> phase_out=0 and phase_idx_out=1 during pause; after resume phase 1 is high 2 more cycles, then phase 2.
- Mask=4'b0100, dwell_in=1 -> phase_out stays 0100; round_done_out pulses every 2 cycles. Mask set to 0 -> IDLE at next advance, all outputs 0.
- sync_clr_in pulse while in phase 3 with en_in=1, mask=1111 -> next cycle phase_out=0001, cnt=0, round_done_out=0.
- rst_n_in low asynchronously mid-phase (between clk_in edges) -> outputs 0 before next clk_in edge. Release with en_in=1 -> restart at phase 0.
